// File: rtl/obi_ram_bank_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : obi_ram_bank_ctrl
// Description : OBI slave front-end for one single-ported SRAM bank. Grants
//               reads and writes in the request cycle, returns rvalid one
//               cycle later and keeps saturating read/write counters.
//               Define OBI_RAM_RMW_EN to turn partial writes into a
//               read-modify-write for macros without byte enables.
// Revision    : 1.0 - initial release
//==============================================================================

package obi_ram_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module obi_ram_bank_ctrl
  import obi_ram_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 8192,
  parameter int unsigned CNT_WIDTH = 16,
  localparam int unsigned AW = $clog2(NUM_WORDS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  obi_req_t             req_i,
  output obi_resp_t            resp_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_be_o,
  input  logic [31:0]          mem_rdata_i,
  input  logic                 clr_cnt_i,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  output logic [CNT_WIDTH-1:0] wr_cnt_o
);

  localparam logic [3:0]           c_be_full = 4'hF;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [AW-1:0]        w_req_word;
  logic                 w_is_empty_wr;
  logic                 w_gnt;
  logic                 w_mem_req;
  logic                 w_mem_we;
  logic [AW-1:0]        w_mem_addr;
  logic [31:0]          w_mem_wdata;
  logic [3:0]           w_mem_be;
  logic                 w_rsp_set;
  logic                 w_rsp_is_wr;
  logic                 r_rvalid;
  logic                 r_rvalid_is_wr;
  logic [CNT_WIDTH-1:0] r_rd_cnt;
  logic [CNT_WIDTH-1:0] r_wr_cnt;
  logic                 w_unused;

  assign w_req_word    = req_i.addr[AW+1:2];
  assign w_is_empty_wr = req_i.we && (req_i.be == 4'h0);
  // Byte offset and bits above the bank are decoded by the crossbar.
  assign w_unused      = ^{req_i.addr[31:AW+2], req_i.addr[1:0]};

`ifdef OBI_RAM_RMW_EN

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    RMW_MERGE = 1'b1
  } state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic          w_is_partial_wr;
  logic          w_rmw_latch;
  logic [AW-1:0] r_rmw_addr;
  logic [31:0]   r_rmw_wdata;
  logic [3:0]    r_rmw_be;
  logic [31:0]   w_merged;

  assign w_is_partial_wr = req_i.we && (req_i.be != 4'h0) && (req_i.be != c_be_full);

  // New bytes where enabled, the freshly read SRAM word elsewhere.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge_byte
    assign w_merged[8*gi +: 8] = r_rmw_be[gi] ? r_rmw_wdata[8*gi +: 8]
                                              : mem_rdata_i[8*gi +: 8];
  end

  // State register and capture of the partial write being merged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_rmw_addr  <= '0;
      r_rmw_wdata <= '0;
      r_rmw_be    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_rmw_latch) begin
        r_rmw_addr  <= w_req_word;
        r_rmw_wdata <= req_i.wdata;
        r_rmw_be    <= req_i.be;
      end
    end
  end

  // Grant, SRAM strobe and next-state decode; everything is quiet in reset
  always_comb begin
    w_gnt        = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    w_mem_be     = '0;
    w_rsp_set    = 1'b0;
    w_rsp_is_wr  = 1'b0;
    w_rmw_latch  = 1'b0;
    w_state_next = r_state;
    if (rst_ni) begin
      case (r_state)
        IDLE: begin
          if (req_i.req) begin
            w_gnt = 1'b1;
            if (w_is_partial_wr) begin
              // Fetch the old word; the response comes after the merge.
              w_mem_req    = 1'b1;
              w_mem_addr   = w_req_word;
              w_rmw_latch  = 1'b1;
              w_state_next = RMW_MERGE;
            end else begin
              w_rsp_set   = 1'b1;
              w_rsp_is_wr = req_i.we;
              if (!req_i.we) begin
                w_mem_req  = 1'b1;
                w_mem_addr = w_req_word;
              end else if (!w_is_empty_wr) begin
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = w_req_word;
                w_mem_wdata = req_i.wdata;
                w_mem_be    = c_be_full;
              end
            end
          end
        end
        RMW_MERGE: begin
          w_mem_req    = 1'b1;
          w_mem_we     = 1'b1;
          w_mem_addr   = r_rmw_addr;
          w_mem_wdata  = w_merged;
          w_mem_be     = c_be_full;
          w_rsp_set    = 1'b1;
          w_rsp_is_wr  = 1'b1;
          w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

`else

  // Grant and SRAM strobe decode; partial writes go straight to the macro
  always_comb begin
    w_gnt       = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_mem_be    = '0;
    w_rsp_set   = 1'b0;
    w_rsp_is_wr = 1'b0;
    if (rst_ni && req_i.req) begin
      w_gnt       = 1'b1;
      w_rsp_set   = 1'b1;
      w_rsp_is_wr = req_i.we;
      if (!req_i.we) begin
        w_mem_req  = 1'b1;
        w_mem_addr = w_req_word;
      end else if (!w_is_empty_wr) begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = w_req_word;
        w_mem_wdata = req_i.wdata;
        w_mem_be    = req_i.be;
      end
    end
  end

`endif

  // Response valid one cycle after the transaction's last SRAM cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid       <= 1'b0;
      r_rvalid_is_wr <= 1'b0;
    end else begin
      r_rvalid       <= w_rsp_set;
      r_rvalid_is_wr <= w_rsp_is_wr;
    end
  end

  // Saturating completion counters; clear wins over a same-cycle increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (r_rvalid) begin
      if (!r_rvalid_is_wr && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + c_cnt_one;
      if (r_rvalid_is_wr && (r_wr_cnt != '1))  r_wr_cnt <= r_wr_cnt + c_cnt_one;
    end
  end

  assign resp_o.gnt    = w_gnt;
  assign resp_o.rvalid = r_rvalid;
  assign resp_o.rdata  = (r_rvalid && !r_rvalid_is_wr) ? mem_rdata_i : 32'h0;

  assign mem_req_o   = w_mem_req;
  assign mem_we_o    = w_mem_we;
  assign mem_addr_o  = w_mem_addr;
  assign mem_wdata_o = w_mem_wdata;
  assign mem_be_o    = w_mem_be;
  assign rd_cnt_o    = r_rd_cnt;
  assign wr_cnt_o    = r_wr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_obi_ram_bank_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_obi_ram_bank_ctrl
// Description : Randomized self-checking bench for obi_ram_bank_ctrl with a
//               transaction-level reference model and a behavioural SRAM.
// Revision    : 1.0 - initial release
//==============================================================================

module tb_obi_ram_bank_ctrl;
  import obi_ram_pkg::*;

  localparam int NW    = 64;
  localparam int AW    = 6;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef OBI_RAM_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  obi_req_t         req;
  obi_resp_t        resp;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic [31:0]      mem_rdata = 32'h0;
  logic             clr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;

  always #5 clk = ~clk;

  obi_ram_bank_ctrl #(
    .NUM_WORDS (NW),
    .CNT_WIDTH (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .resp_o      (resp),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata),
    .clr_cnt_i   (clr_cnt),
    .rd_cnt_o    (rd_cnt),
    .wr_cnt_o    (wr_cnt)
  );

  // Behavioural SRAM macro with byte enables and a one-cycle read; the
  // preload port fills it while the DUT is held in reset.
  logic [31:0]   sram [NW];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr;
  logic [31:0]   pre_data;

  always @(posedge clk) begin
    if (pre_en) begin
      sram[pre_addr] <= pre_data;
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // Reference model: the word each transaction should see, when each
  // response is due, and the counters those responses should produce.
  typedef struct {
    int          due;
    bit          is_rd;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]   ref_mem [NW];
  rsp_t          rq[$];
  int            cyc;
  int            free_cyc;
  int            merge_cyc;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_be;
  int            m_rd_cnt;
  int            m_wr_cnt;
  bit            granted;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d, t=%0t)", tag, act, exp, cyc, $time);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Compare one cycle of DUT outputs against the model, then advance it.
  task automatic check_cycle();
    bit            exp_gnt, exp_mreq, exp_mwe, exp_rv, rv_is_rd;
    logic [AW-1:0] exp_maddr, w;
    logic [31:0]   exp_mwd, exp_rd;
    logic [3:0]    exp_mbe;
    rsp_t          r;
    exp_gnt   = req.req && (cyc >= free_cyc);
    exp_mreq  = 1'b0;
    exp_mwe   = 1'b0;
    exp_maddr = '0;
    exp_mwd   = '0;
    exp_mbe   = '0;
    if (cyc == merge_cyc) begin
      exp_mreq  = 1'b1;
      exp_mwe   = 1'b1;
      exp_maddr = m_addr;
      exp_mbe   = 4'hF;
      exp_mwd   = merge_bytes(ref_mem[m_addr], m_wdata, m_be);
      ref_mem[m_addr] = exp_mwd;
      rq.push_back('{cyc + 1, 1'b0, 32'h0});
    end
    if (exp_gnt) begin
      w        = req.addr[AW+1:2];
      free_cyc = cyc + 1;
      if (!req.we) begin
        exp_mreq  = 1'b1;
        exp_maddr = w;
        rq.push_back('{cyc + 1, 1'b1, ref_mem[w]});
      end else if (req.be == 4'h0) begin
        rq.push_back('{cyc + 1, 1'b0, 32'h0});
      end else if (req.be == 4'hF || !RMW) begin
        exp_mreq  = 1'b1;
        exp_mwe   = 1'b1;
        exp_maddr = w;
        exp_mwd   = req.wdata;
        exp_mbe   = req.be;
        ref_mem[w] = merge_bytes(ref_mem[w], req.wdata, req.be);
        rq.push_back('{cyc + 1, 1'b0, 32'h0});
      end else begin
        exp_mreq  = 1'b1;
        exp_maddr = w;
        merge_cyc = cyc + 1;
        m_addr    = w;
        m_wdata   = req.wdata;
        m_be      = req.be;
        free_cyc  = cyc + 2;
      end
    end
    chk_eq("gnt", 32'(resp.gnt), 32'(exp_gnt));
    chk_eq("mem_req", 32'(mem_req), 32'(exp_mreq));
    if (exp_mreq) begin
      chk_eq("mem_we", 32'(mem_we), 32'(exp_mwe));
      chk_eq("mem_addr", 32'(mem_addr), 32'(exp_maddr));
      if (exp_mwe) begin
        chk_eq("mem_be", 32'(mem_be), 32'(exp_mbe));
        chk_eq("mem_wdata", mem_wdata, exp_mwd);
      end
    end
    exp_rv   = (rq.size() > 0) && (rq[0].due == cyc);
    exp_rd   = 32'h0;
    rv_is_rd = 1'b0;
    if (exp_rv) begin
      r        = rq.pop_front();
      rv_is_rd = r.is_rd;
      exp_rd   = r.data;
    end
    chk_eq("rvalid", 32'(resp.rvalid), 32'(exp_rv));
    chk_eq("rdata", resp.rdata, exp_rd);
    chk_eq("rd_cnt", 32'(rd_cnt), 32'(m_rd_cnt));
    chk_eq("wr_cnt", 32'(wr_cnt), 32'(m_wr_cnt));
    if (clr_cnt) begin
      m_rd_cnt = 0;
      m_wr_cnt = 0;
    end else if (exp_rv) begin
      if (rv_is_rd && m_rd_cnt < CNT_MAX) m_rd_cnt++;
      if (!rv_is_rd && m_wr_cnt < CNT_MAX) m_wr_cnt++;
    end
    granted = exp_gnt;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_txn(input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int k;
    req     = '{1'b1, we, be, addr, wdata};
    granted = 1'b0;
    k       = 0;
    while (!granted && k < 4) begin
      tick();
      k++;
    end
    req.req = 1'b0;
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pre_en   = 1'b1;
    pre_addr = AW'(a);
    pre_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_gnt"}, 32'(resp.gnt), 32'h0);
    chk_eq({tag, "_rvalid"}, 32'(resp.rvalid), 32'h0);
    chk_eq({tag, "_rdata"}, resp.rdata, 32'h0);
    chk_eq({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    chk_eq({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk_eq({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk_eq({tag, "_mem_be"}, 32'(mem_be), 32'h0);
    chk_eq({tag, "_rd_cnt"}, 32'(rd_cnt), 32'h0);
    chk_eq({tag, "_wr_cnt"}, 32'(wr_cnt), 32'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clr_cnt   = 1'b0;
    req       = '{1'b1, 1'b0, 4'hF, 32'h10, 32'h0};
    cyc       = 0;
    free_cyc  = 0;
    merge_cyc = -1;
    m_rd_cnt  = 0;
    m_wr_cnt  = 0;

    // Fill the SRAM during reset, with a request held high to show gating.
    for (int i = 0; i < NW; i++) preload(i, $urandom());
    preload(4, 32'hDEAD_BEEF);
    preload(3, 32'hAABB_CCDD);
    @(negedge clk);
    check_all_zero("reset");
    req.req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Read of word 4 in the first cycle out of reset.
    do_txn(1'b0, 4'hF, 32'h0000_0010, 32'h0);
    // Full-word write to word 2, then read it back.
    do_txn(1'b1, 4'hF, 32'h0000_0008, 32'h1234_5678);
    do_txn(1'b0, 4'hF, 32'h0000_0008, 32'h0);
    // Partial write to word 3 with a read queued right behind it.
    do_txn(1'b1, 4'b0101, 32'h0000_000C, 32'h1122_3344);
    do_txn(1'b0, 4'hF, 32'h0000_000C, 32'h0);
    // Empty write leaves the word intact.
    do_txn(1'b1, 4'h0, 32'h0000_000C, 32'hFFFF_FFFF);
    do_txn(1'b0, 4'hF, 32'h0000_000C, 32'h0);
    tick();
    tick();

    // Randomized traffic, back-to-back with occasional idle cycles.
    for (int n = 0; n < 600; n++) begin
      int          op;
      logic [3:0]  be;
      op      = $urandom_range(0, 3);
      be      = (op == 3) ? 4'($urandom_range(1, 14)) : ((op == 2) ? 4'h0 : 4'hF);
      clr_cnt = ($urandom_range(0, 49) == 0);
      do_txn(op != 0, be, $urandom(), $urandom());
      clr_cnt = 1'b0;
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick();
    tick();

    // Read counter saturation, then a clear racing a read response.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int n = 0; n < CNT_MAX + 2; n++) do_txn(1'b0, 4'hF, $urandom(), 32'h0);
    tick();
    chk_eq("rd_cnt_sat", 32'(rd_cnt), 32'(CNT_MAX));
    do_txn(1'b0, 4'hF, 32'h0000_0010, 32'h0);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk_eq("rd_cnt_clr", 32'(rd_cnt), 32'h0);
    tick();

    // Reset in the middle of a transaction drops it without side effects.
    if (RMW) do_txn(1'b1, 4'b0011, 32'h0000_0020, 32'hCAFE_F00D);
    else     do_txn(1'b0, 4'hF, 32'h0000_0020, 32'h0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    rq.delete();
    merge_cyc = -1;
    m_rd_cnt  = 0;
    m_wr_cnt  = 0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n    = 1'b1;
    free_cyc = cyc;
    tick();
    tick();
    do_txn(1'b0, 4'hF, 32'h0000_0020, 32'h0);
    do_txn(1'b1, 4'b1000, 32'h0000_0020, 32'h5500_0000);
    do_txn(1'b0, 4'hF, 32'h0000_0020, 32'h0);
    tick();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/obi_ram_bank_ctrl.md
OBI_RAM_BANK_CTRL -- requirements
Module: obi_ram_bank_ctrl

Interface
REQ-001 Parameter NUM_WORDS, default 8192, words per bank (power of two); AW = $clog2(NUM_WORDS).
REQ-002 Parameter CNT_WIDTH, default 16, width of access counters.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 req_i  input  obi_req_t  OBI slave request from the system crossbar RAM port (req, we, be[3:0], addr[31:0], wdata[31:0]).
REQ-006 resp_o  output  obi_resp_t  OBI response to the crossbar (gnt, rvalid, rdata[31:0]).
REQ-007 mem_req_o  output  1  SRAM macro access strobe.
REQ-008 mem_we_o  output  1  SRAM write enable (1 = write).
REQ-009 mem_addr_o  output  AW  SRAM word index, equal to addr[AW+1:2].
REQ-010 mem_wdata_o  output  32  SRAM write data.
REQ-011 mem_be_o  output  4  SRAM byte enables.
REQ-012 mem_rdata_i  input  32  SRAM read data, valid the cycle after a read strobe.
REQ-013 clr_cnt_i  input  1  synchronous clear of both counters.
REQ-014 rd_cnt_o / wr_cnt_o  output  CNT_WIDTH each  completed read / write counts.

Function
REQ-015 Reads, full-word writes (be=4'hF) and empty writes (be=4'h0) SHALL be granted combinationally in the cycle req is high while the FSM is IDLE.
REQ-016 A granted read SHALL drive mem_req_o=1, mem_we_o=0 in the grant cycle; rvalid SHALL assert exactly one cycle later with rdata=mem_rdata_i.
REQ-017 A granted full-word write SHALL drive mem_req_o=1, mem_we_o=1, mem_be_o=4'hF, mem_wdata_o=wdata in the grant cycle; rvalid one cycle later with rdata=0.
REQ-018 A granted empty write SHALL issue no SRAM access; rvalid one cycle later with rdata=0.
REQ-019 rdata SHALL be 0 whenever rvalid is 0.
REQ-020 At most one transaction SHALL be outstanding; back-to-back single-cycle accesses SHALL sustain one grant per cycle.
REQ-021 rd_cnt_o increments on each read rvalid, wr_cnt_o on each write rvalid; both saturate at all-ones; clr_cnt_i has priority over increment.
REQ-022 Partial writes (be not 4'h0/4'hF) SHALL follow REQ-029/REQ-030 depending on configuration.

Reset
REQ-023 While rst_ni=0: gnt=0, rvalid=0, rdata=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0, counters=0, FSM=IDLE.
REQ-024 Reset asserted mid-RMW SHALL abandon the operation: no SRAM write issued, pending rvalid dropped.
REQ-025 First grant possible in the first cycle after rst_ni deasserts.

Configuration
REQ-026 Macro OBI_RAM_RMW_EN selects read-modify-write handling of partial writes for SRAM macros without byte enables.
REQ-027 With OBI_RAM_RMW_EN defined, mem_be_o SHALL be 4'hF on every write and FSM states SHALL be IDLE, RMW_MERGE.
REQ-028 Without OBI_RAM_RMW_EN, FSM SHALL be absent and partial writes SHALL be handled as full-word writes per REQ-017 but with mem_be_o=be.
REQ-029 (RMW) IDLE, partial write: gnt=1, latch addr/wdata/be, issue SRAM read at addr, go RMW_MERGE.
REQ-030 (RMW) RMW_MERGE: gnt=0; issue SRAM write at latched addr with, per byte i, wdata byte if be[i] else mem_rdata_i byte; return to IDLE; rvalid asserted the following cycle with rdata=0.
REQ-031 (RMW) A request present during RMW_MERGE SHALL be held ungranted and granted in the next IDLE cycle; a partial write has 2-cycle grant-to-grant occupancy, 2-cycle grant-to-rvalid latency.

Verification
REQ-032 Read addr 0x0000_0010, SRAM word 4 = 0xDEAD_BEEF -> gnt same cycle, mem_addr_o=4, rvalid+1 with rdata 0xDEAD_BEEF, rd_cnt_o=1.
REQ-033 Write addr 0x8, be=4'hF, wdata 0x1234_5678 -> mem_we_o=1, mem_addr_o=2, rvalid+1 rdata 0, wr_cnt_o=1.
REQ-034 RMW_EN: word 3 = 0xAABB_CCDD, write addr 0xC be=4'b0101 wdata 0x1122_3344 -> read cycle, then write 0xAA22_CC44 be=4'hF, rvalid 2 cycles after grant; read request in RMW_MERGE granted one cycle later.
REQ-035 No RMW_EN: same write -> single cycle, mem_be_o=4'b0101, mem_wdata_o=0x1122_3344.
REQ-036 Force rd_cnt_o to 16'hFFFE, issue 3 reads -> saturates at 16'hFFFF; clr_cnt_i with concurrent read rvalid -> 0.
REQ-037 rst_ni low during RMW_MERGE -> no mem write, no rvalid, all outputs 0, IDLE after release.
